// File: rtl/alu_exe_pkg.sv
// alu_exe_pkg: op codes, issue-bundle layout, result FIFO entry and FSM state shared by the ALU execute stage.
package alu_exe_pkg;
    localparam int FIFO_DEPTH = 3;
    localparam int BUNDLE_W   = 177;
    localparam int OPR_LSB    = 0;
    localparam int OPL_LSB    = 32;
    localparam int OP_LSB     = 64;
    localparam int RD_LSB     = 68;
    localparam int WE_BIT     = 73;
    localparam int TAG_LSB    = 74;
    localparam int INSTR_TOP  = 176;

    localparam logic [3:0] NO_TAG   = 4'hF;
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_PASSR = 4'd10;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } fifo_entry_t;

    typedef enum logic {ST_RUN = 1'b0, ST_SHIFT = 1'b1} state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r);
        case (op)
            OP_ADD:   return l + r;
            OP_SUB:   return l - r;
            OP_SLL:   return l << r[4:0];
            OP_SLT:   return {31'd0, $signed(l) < $signed(r)};
            OP_SLTU:  return {31'd0, l < r};
            OP_XOR:   return l ^ r;
            OP_SRL:   return l >> r[4:0];
            OP_SRA:   return $unsigned($signed(l) >>> r[4:0]);
            OP_OR:    return l | r;
            OP_AND:   return l & r;
            OP_PASSR: return r;
            default:  return 32'h0;
        endcase
    endfunction
endpackage

// File: rtl/alu_exe_result_fifo.sv
// alu_exe_result_fifo: 3-entry result queue with modulo-3 pointers and simultaneous push/pop.
module alu_exe_result_fifo
    import alu_exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_Push_1,
    input  fifo_entry_t i_Entry,
    input  logic        i_Pop_1,
    output logic        o_Valid_1,
    output fifo_entry_t o_Head,
    output logic [1:0]  o_Count_2
);
    localparam logic [1:0] LAST = 2'(FIFO_DEPTH - 1);

    fifo_entry_t r_mem [FIFO_DEPTH];
    logic [1:0]  r_wr, r_rd, r_count;
    logic        w_push, w_pop;

    assign w_pop  = i_Pop_1 & (r_count != 2'd0);
    assign w_push = i_Push_1 & ((r_count != 2'(FIFO_DEPTH)) | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= 2'd0;
            r_rd    <= 2'd0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_Entry;
                r_wr        <= (r_wr == LAST) ? 2'd0 : r_wr + 2'd1;
            end
            if (w_pop) r_rd <= (r_rd == LAST) ? 2'd0 : r_rd + 2'd1;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_Valid_1 = r_count != 2'd0;
    assign o_Head    = r_mem[r_rd];
    assign o_Count_2 = r_count;
endmodule

// File: rtl/alu_exe_stage.sv
// alu_exe_stage: ALU execute stage (S1 register, compute, bypass broadcast, result FIFO to writeback).
// Define ALU_EXE_SERIAL_SHIFT_EN to run SLL/SRL/SRA one bit per cycle instead of a barrel shifter.
module alu_exe_stage
    import alu_exe_pkg::*;
#(
    parameter int FIFO_DEPTH = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [176:0] i_InstructionToExe_177,
    input  logic         i_Drive_IssueToExe_1,
    output logic         o_Free_ExeToIssue_1,
    output logic         o_Drive_ExeToWb_1,
    input  logic         i_Free_WbToExe_1,
    output logic [4:0]   o_WbRd_5,
    output logic         o_WbEn_1,
    output logic [31:0]  o_WbData_32,
    output logic         o_BypassWrEn_1,
    output logic [3:0]   o_BypassTag_4,
    output logic [31:0]  o_BypassData_32
);
    localparam logic [2:0] CAP = 3'(FIFO_DEPTH);

    logic        r_init, r_s1_valid, r_s1_we, r_byp_en;
    logic [3:0]  r_s1_op, r_s1_tag, r_byp_tag;
    logic [4:0]  r_s1_rd;
    logic [31:0] r_s1_opl, r_s1_opr, r_byp_data;
    logic        w_in_xfer, w_run, w_s1_go, w_push, w_pop, w_fifo_valid, w_unused;
    logic [3:0]  w_push_tag;
    logic [1:0]  w_count;
    fifo_entry_t w_push_entry, w_head;

    assign w_unused            = ^i_InstructionToExe_177[INSTR_TOP:TAG_LSB+4];
    // r_init keeps ready low until the first edge after reset
    assign o_Free_ExeToIssue_1 = r_init & w_run & (({1'b0, w_count} + {2'b0, r_s1_valid}) < CAP);
    assign w_in_xfer           = i_Drive_IssueToExe_1 & o_Free_ExeToIssue_1;
    assign w_pop               = w_fifo_valid & i_Free_WbToExe_1;

`ifdef ALU_EXE_SERIAL_SHIFT_EN
    state_t      r_state, w_state_nxt;
    logic [4:0]  r_sh_cnt, r_sh_rd;
    logic [3:0]  r_sh_op, r_sh_tag;
    logic        r_sh_we, w_s1_shift, w_s1_push, w_sh_done;
    logic [31:0] r_sh_val, w_sh_nxt, w_s1_result;

    assign w_run       = r_state == ST_RUN;
    assign w_s1_shift  = r_s1_valid & w_run & is_shift(r_s1_op) & (r_s1_opr[4:0] != 5'd0);
    assign w_s1_push   = r_s1_valid & w_run & ~w_s1_shift;
    assign w_sh_done   = (r_state == ST_SHIFT) & (r_sh_cnt == 5'd1);
    assign w_sh_nxt    = (r_sh_op == OP_SLL) ? {r_sh_val[30:0], 1'b0} :
                         (r_sh_op == OP_SRL) ? {1'b0, r_sh_val[31:1]} : {r_sh_val[31], r_sh_val[31:1]};
    // shifts reaching this path have shamt 0, so the value passes through
    assign w_s1_result = is_shift(r_s1_op) ? r_s1_opl : alu_calc(r_s1_op, r_s1_opl, r_s1_opr);
    assign w_s1_go     = w_s1_push | w_s1_shift;
    assign w_push      = w_s1_push | w_sh_done;
    assign w_push_entry = w_sh_done ? {r_sh_rd, r_sh_we, w_sh_nxt} : {r_s1_rd, r_s1_we, w_s1_result};
    assign w_push_tag  = w_sh_done ? r_sh_tag : r_s1_tag;

    always_comb begin
        w_state_nxt = r_state;
        if (w_s1_shift) w_state_nxt = ST_SHIFT;
        else if (w_sh_done) w_state_nxt = ST_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_sh_cnt <= 5'd0;
            r_sh_rd  <= 5'd0;
            r_sh_op  <= 4'd0;
            r_sh_tag <= 4'd0;
            r_sh_we  <= 1'b0;
            r_sh_val <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_s1_shift) begin
                r_sh_cnt <= r_s1_opr[4:0];
                r_sh_rd  <= r_s1_rd;
                r_sh_op  <= r_s1_op;
                r_sh_tag <= r_s1_tag;
                r_sh_we  <= r_s1_we;
                r_sh_val <= r_s1_opl;
            end else if (r_state == ST_SHIFT) begin
                r_sh_cnt <= r_sh_cnt - 5'd1;
                r_sh_val <= w_sh_nxt;
            end
        end
    end
`else
    assign w_run        = 1'b1;
    assign w_s1_go      = r_s1_valid;
    assign w_push       = r_s1_valid;
    assign w_push_entry = {r_s1_rd, r_s1_we, alu_calc(r_s1_op, r_s1_opl, r_s1_opr)};
    assign w_push_tag   = r_s1_tag;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init     <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_we    <= 1'b0;
            r_s1_op    <= 4'd0;
            r_s1_tag   <= 4'd0;
            r_s1_rd    <= 5'd0;
            r_s1_opl   <= 32'd0;
            r_s1_opr   <= 32'd0;
            r_byp_en   <= 1'b0;
            r_byp_tag  <= 4'd0;
            r_byp_data <= 32'd0;
        end else begin
            r_init <= 1'b1;
            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= i_InstructionToExe_177[OP_LSB +: 4];
                r_s1_rd    <= i_InstructionToExe_177[RD_LSB +: 5];
                r_s1_we    <= i_InstructionToExe_177[WE_BIT];
                r_s1_tag   <= i_InstructionToExe_177[TAG_LSB +: 4];
                r_s1_opl   <= i_InstructionToExe_177[OPL_LSB +: 32];
                r_s1_opr   <= i_InstructionToExe_177[OPR_LSB +: 32];
            end else if (w_s1_go) begin
                r_s1_valid <= 1'b0;
            end
            r_byp_en <= w_push & (w_push_tag != NO_TAG);
            if (w_push) begin
                r_byp_tag  <= w_push_tag;
                r_byp_data <= w_push_entry.data;
            end
        end
    end

    alu_exe_result_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_Push_1  (w_push),
        .i_Entry   (w_push_entry),
        .i_Pop_1   (w_pop),
        .o_Valid_1 (w_fifo_valid),
        .o_Head    (w_head),
        .o_Count_2 (w_count)
    );

    assign o_Drive_ExeToWb_1 = w_fifo_valid;
    assign o_WbRd_5          = w_head.rd;
    assign o_WbEn_1          = w_head.we;
    assign o_WbData_32       = w_head.data;
    assign o_BypassWrEn_1    = r_byp_en;
    assign o_BypassTag_4     = r_byp_tag;
    assign o_BypassData_32   = r_byp_data;
endmodule
